// File: rtl/norm_shift_if.sv
// Operand/result handshake bundle for norm_shift: unnormalized input side, normalized output side.
// master = upstream/downstream environment, slave = the normalizer.
interface norm_shift_if #(
  parameter int WIDTH = 32,
  parameter int EXP_W = 8
);
  localparam int LZW = $clog2(WIDTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LZW-1:0]   in_lzc;
  logic [EXP_W-1:0] in_exp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mant;
  logic [EXP_W-1:0] out_exp;
  logic             out_zero;
  logic             out_uflow;
  logic             err;

  modport master (
    output in_valid, in_data, in_lzc, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow, err
  );

  modport slave (
    input  in_valid, in_data, in_lzc, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow, err
  );
endinterface

// File: rtl/norm_shift.sv
// Mantissa normalizer: shift left by supplied leading-zero count, adjust exponent with underflow saturation.
// Latency 2 cycles (S1 shift/subtract, S2 saturate/register); in_ready drops only when both stages hold and out_ready=0.
module norm_shift #(
  parameter int WIDTH = 32,
  parameter int EXP_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  norm_shift_if.slave bus
);
  localparam int SW  = $clog2(WIDTH);
  localparam int LZW = SW + 1;
  localparam logic [SW-1:0]  TOP_POS = SW'(WIDTH - 1);
  localparam logic [LZW-1:0] LZ_ALL  = LZW'(WIDTH);

  logic                    s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0]        s1_mant_q, s1_mant_d;
  logic signed [EXP_W:0]   s1_exp_q, s1_exp_d;
  logic                    s1_zero_q, s1_zero_d;
  logic                    s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0]        out_mant_q, out_mant_d;
  logic [EXP_W-1:0]        out_exp_q, out_exp_d;
  logic                    out_zero_q, out_zero_d;
  logic                    out_uflow_q, out_uflow_d;
  logic                    err_q, err_d;

  logic                    s2_adv, s1_adv, in_fire, lzc_bad;
  logic [SW-1:0]           lzc_lo, lead_pos;

  assign s2_adv  = !s2_vld_q || bus.out_ready;
  assign s1_adv  = !s1_vld_q || s2_adv;
  assign in_fire = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = s1_adv && rst_n;
  assign bus.out_valid = s2_vld_q;
  assign bus.out_mant  = out_mant_q;
  assign bus.out_exp   = out_exp_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_uflow = out_uflow_q;
  assign bus.err       = err_q;

  always_comb begin
    lzc_lo   = bus.in_lzc[SW-1:0];
    lead_pos = TOP_POS - lzc_lo;
    // A consistent count leaves exactly one set bit after shifting the leading one down to bit 0
    if (bus.in_data == '0) begin
      lzc_bad = (bus.in_lzc != LZ_ALL);
    end else begin
      lzc_bad = bus.in_lzc[LZW-1] || ((bus.in_data >> lead_pos) != WIDTH'(1));
    end
  end

  always_comb begin
    s1_vld_d    = s1_adv ? in_fire : s1_vld_q;
    s1_mant_d   = s1_mant_q;
    s1_exp_d    = s1_exp_q;
    s1_zero_d   = s1_zero_q;
    s2_vld_d    = s2_adv ? s1_vld_q : s2_vld_q;
    out_mant_d  = out_mant_q;
    out_exp_d   = out_exp_q;
    out_zero_d  = out_zero_q;
    out_uflow_d = out_uflow_q;
    err_d       = err_q || (in_fire && lzc_bad);

    if (in_fire) begin
      s1_mant_d = bus.in_data << lzc_lo;
      s1_exp_d  = $signed({bus.in_exp[EXP_W-1], bus.in_exp})
                - $signed({{(EXP_W + 1 - LZW){1'b0}}, bus.in_lzc});
      s1_zero_d = bus.in_lzc[LZW-1];
    end

    if (s2_adv && s1_vld_q) begin
      if (s1_zero_q) begin
        out_mant_d  = '0;
        out_exp_d   = '0;
        out_zero_d  = 1'b1;
        out_uflow_d = 1'b0;
      end else begin
        out_mant_d = s1_mant_q;
        out_zero_d = 1'b0;
        // Only a downward overflow is reachable: top two bits 10 means below the EXP_W-bit minimum
        if (s1_exp_q[EXP_W] && !s1_exp_q[EXP_W-1]) begin
          out_exp_d   = {1'b1, {(EXP_W - 1){1'b0}}};
          out_uflow_d = 1'b1;
        end else begin
          out_exp_d   = s1_exp_q[EXP_W-1:0];
          out_uflow_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_mant_q   <= '0;
      s1_exp_q    <= '0;
      s1_zero_q   <= 1'b0;
      s2_vld_q    <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_zero_q  <= 1'b0;
      out_uflow_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_mant_q   <= s1_mant_d;
      s1_exp_q    <= s1_exp_d;
      s1_zero_q   <= s1_zero_d;
      s2_vld_q    <= s2_vld_d;
      out_mant_q  <= out_mant_d;
      out_exp_q   <= out_exp_d;
      out_zero_q  <= out_zero_d;
      out_uflow_q <= out_uflow_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_norm_shift.sv
// Randomized and directed bench for norm_shift against an arithmetic reference model and scoreboard queue.
module tb_norm_shift;
  localparam int W = 32;
  localparam int E = 8;

  typedef struct packed {
    logic [31:0] mant;
    logic [7:0]  exp;
    logic        zero;
    logic        uflow;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  norm_shift_if #(.WIDTH(W), .EXP_W(E)) bus();
  norm_shift #(.WIDTH(W), .EXP_W(E)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  res_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   err_m, in_fire, out_fire, rnd_rdy;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int true_lzc(logic [31:0] d);
    for (int i = 31; i >= 0; i--) if (d[i]) return 31 - i;
    return 32;
  endfunction

  function automatic res_t model(logic [31:0] d, logic [5:0] lz, logic [7:0] e);
    res_t r;
    int x;
    logic [63:0] wide;
    r = '0;
    if (lz >= 6'd32) begin
      r.zero = 1'b1;
      return r;
    end
    wide   = 64'(d) << lz;
    r.mant = wide[31:0];
    x = int'($signed(e)) - int'(lz);
    if (x < -128) begin
      r.exp   = 8'h80;
      r.uflow = 1'b1;
    end else begin
      r.exp = 8'(x);
    end
    return r;
  endfunction

  task automatic tick();
    if (rnd_rdy) bus.out_ready = ($urandom_range(3) != 0);
    @(negedge clk);
    in_fire  = bus.in_valid && bus.in_ready;
    out_fire = bus.out_valid && bus.out_ready;
    if (bus.out_valid) begin
      if (q.size() == 0) chk("stale_out", 64'(bus.out_valid), 64'(0));
      else chk("result", 64'({bus.out_mant, bus.out_exp, bus.out_zero, bus.out_uflow}), 64'(q[0]));
    end
    if (out_fire && q.size() > 0) void'(q.pop_front());
    if (in_fire) begin
      q.push_back(model(bus.in_data, bus.in_lzc, bus.in_exp));
      if (true_lzc(bus.in_data) != int'(bus.in_lzc)) err_m = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("err", 64'(bus.err), 64'(err_m));
  endtask

  task automatic drive(logic [31:0] d, logic [5:0] lz, logic [7:0] e);
    bus.in_data  = d;
    bus.in_lzc   = lz;
    bus.in_exp   = e;
    bus.in_valid = 1'b1;
  endtask

  task automatic send(logic [31:0] d, logic [5:0] lz, logic [7:0] e);
    int n = 0;
    drive(d, lz, e);
    do begin
      tick();
      n++;
    end while (!in_fire && n < 100);
    if (!in_fire) chk("send_timeout", 64'(in_fire), 64'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid  = 1'b0;
    rnd_rdy       = 1'b0;
    bus.out_ready = 1'b1;
    while (q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    chk("drain_empty", 64'(q.size()), 64'(0));
  endtask

  task automatic rand_op(output logic [31:0] d, output logic [5:0] lz, output logic [7:0] e);
    int t;
    logic [63:0] one;
    t = $urandom_range(32, 0);
    if (t == 32) begin
      d = '0;
    end else begin
      one = 64'(1) << (31 - t);
      d   = 32'(one) | ($urandom & 32'(one - 64'(1)));
    end
    lz = 6'(t);
    if ($urandom_range(15) == 0) lz = 6'($urandom_range(32, 0));
    e = 8'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [5:0]  lz;
    logic [7:0]  e;

    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_lzc = '0; bus.in_exp = '0;
    bus.out_ready = 1'b0; rnd_rdy = 1'b0; err_m = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_err", 64'(bus.err), 64'(0));
    chk("rst_outs", 64'({bus.out_mant, bus.out_exp, bus.out_zero, bus.out_uflow}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", 64'(bus.in_ready), 64'(1));

    // Two-cycle latency with known values
    bus.out_ready = 1'b1;
    drive(32'h0001_0000, 6'd15, 8'd10);
    tick();
    chk("lat_accept", 64'(in_fire), 64'(1));
    bus.in_valid = 1'b0;
    chk("lat_c1_valid", 64'(bus.out_valid), 64'(0));
    tick();
    chk("lat_c2_valid", 64'(bus.out_valid), 64'(1));
    chk("lat_mant", 64'(bus.out_mant), 64'(32'h8000_0000));
    chk("lat_exp", 64'(bus.out_exp), 64'(8'hFB));
    chk("lat_flags", 64'({bus.out_zero, bus.out_uflow}), 64'(0));
    drain();

    // All-zero operand
    send(32'h0, 6'd32, 8'd7);
    tick();
    chk("zero_flag", 64'(bus.out_zero), 64'(1));
    chk("zero_mant_exp", 64'({bus.out_mant, bus.out_exp, bus.out_uflow}), 64'(0));
    drain();
    chk("zero_no_err", 64'(bus.err), 64'(0));

    // Exponent underflow saturation
    send(32'h0000_0001, 6'd31, 8'h88);
    tick();
    chk("uf_mant", 64'(bus.out_mant), 64'(32'h8000_0000));
    chk("uf_exp", 64'(bus.out_exp), 64'(8'h80));
    chk("uf_flag", 64'(bus.out_uflow), 64'(1));
    drain();

    // Inconsistent count sets sticky err, data path unaffected
    send(32'h0001_0000, 6'd14, 8'd3);
    chk("err_set", 64'(bus.err), 64'(1));
    tick();
    chk("err_mant", 64'(bus.out_mant), 64'(32'h4000_0000));
    send(32'h0080_0000, 6'd8, 8'd0);
    drain();
    chk("err_sticky", 64'(bus.err), 64'(1));

    // Backpressure: two accepted, third held, then drain in order
    bus.out_ready = 1'b0;
    drive(32'h8000_0000, 6'd0, 8'd1);
    tick();
    chk("bp_acc1", 64'(in_fire), 64'(1));
    drive(32'h0000_0300, 6'd22, 8'hFD);
    tick();
    chk("bp_acc2", 64'(in_fire), 64'(1));
    drive(32'h0000_F000, 6'd16, 8'd100);
    tick();
    chk("bp_blocked", 64'(in_fire), 64'(0));
    chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
    tick();
    chk("bp_held_valid", 64'(bus.out_valid), 64'(1));
    bus.out_ready = 1'b1;
    tick();
    chk("bp_out1", 64'(out_fire), 64'(1));
    chk("bp_acc3_no_bubble", 64'(in_fire), 64'(1));
    bus.in_valid = 1'b0;
    tick();
    chk("bp_out2", 64'(out_fire), 64'(1));
    tick();
    chk("bp_out3", 64'(out_fire), 64'(1));
    chk("bp_done", 64'(q.size()), 64'(0));

    // Reset with both stages occupied
    bus.out_ready = 1'b0;
    send(32'h0000_4000, 6'd17, 8'd20);
    send(32'h1234_5678, 6'd3, 8'd9);
    chk("pre_rst_valid", 64'(bus.out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_err", 64'(bus.err), 64'(0));
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
    q.delete();
    err_m = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    bus.out_ready = 1'b1;
    repeat (6) tick();
    chk("post_rst_no_stale", 64'(bus.out_valid), 64'(0));

    // Random traffic with random downstream stalls
    rnd_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rand_op(d, lz, e);
      send(d, lz, e);
      if ($urandom_range(7) == 0) tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
